// File: rtl/memory_responder_pkg.sv
// Shared word size, default geometry/latency and per-port FSM state encoding
// for the dual-port memory responder.
package memory_responder_pkg;

  localparam int unsigned WORD_SIZE     = 16;
  localparam int unsigned MEM_DEPTH_DEF = 256;
  localparam int unsigned LATENCY_DEF   = 2;
  localparam int unsigned CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } port_state_e;

endpackage

// File: rtl/mem_port_fsm.sv
// Per-port request sequencer: samples a request in IDLE, counts out the
// access latency in WAIT and flags the single DONE cycle.
module mem_port_fsm
  import memory_responder_pkg::*;
#(
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_req,
  output logic o_sample,
  output logic o_enter_done,
  output logic o_done
);

  port_state_e      r_state, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    o_sample   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          o_sample   = 1'b1;
          w_cnt_next = CNT_W'(LATENCY - 1);
          w_next     = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
      default: begin
        w_next     = ST_IDLE;
        w_cnt_next = '0;
      end
    endcase
    o_enter_done = (w_next == ST_DONE);
    o_done       = (r_state == ST_DONE);
  end

endmodule

// File: rtl/memory_responder.sv
// Dual-port memory responder: port 1 read-only, port 2 read/write over a
// shared tristate data bus, each port with a fixed-latency ready/ack pulse.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int unsigned LATENCY   = LATENCY_DEF,
  parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM1,
  input  logic [WORD_SIZE-1:0] address1,
  output logic [WORD_SIZE-1:0] data1,
  output logic                 inputReady1,
  input  logic                 readM2,
  input  logic                 writeM2,
  input  logic [WORD_SIZE-1:0] address2,
  inout  wire  [WORD_SIZE-1:0] data2,
  output logic                 inputReady2,
  output logic                 ackOutput2
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [WORD_SIZE-1:0] r_mem [MEM_DEPTH];
  logic [AW-1:0]        r_addr1, r_addr2, w_rd_addr1;
  logic                 r_wr2;
  logic [WORD_SIZE-1:0] r_wdata2, r_data1;
  logic                 w_sample1, w_enter1, w_done1;
  logic                 w_sample2, w_enter2, w_done2;
  logic                 w_req2;
  logic                 w_unused_bits;

  assign w_req2 = readM2 | writeM2;

  mem_port_fsm #(.LATENCY(LATENCY)) u_port1 (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req        (readM1),
    .o_sample     (w_sample1),
    .o_enter_done (w_enter1),
    .o_done       (w_done1)
  );

  mem_port_fsm #(.LATENCY(LATENCY)) u_port2 (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_req        (w_req2),
    .o_sample     (w_sample2),
    .o_enter_done (w_enter2),
    .o_done       (w_done2)
  );

  // With LATENCY=1 the sample and DONE-entry edges coincide, so bypass the latch.
  assign w_rd_addr1 = w_sample1 ? address1[AW-1:0] : r_addr1;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr1 <= '0;
      r_data1 <= '0;
    end else begin
      if (w_sample1) r_addr1 <= address1[AW-1:0];
      if (w_enter1)  r_data1 <= r_mem[w_rd_addr1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr2  <= '0;
      r_wr2    <= 1'b0;
      r_wdata2 <= '0;
    end else if (w_sample2) begin
      r_addr2  <= address2[AW-1:0];
      r_wr2    <= writeM2;
      r_wdata2 <= data2;
    end
  end

  // Commit lands at the end of DONE, so coincident reads still see the old word.
  always_ff @(posedge clk) begin
    if (reset_n && w_done2 && r_wr2) r_mem[r_addr2] <= r_wdata2;
  end

  assign data1       = r_data1;
  assign inputReady1 = w_done1;
  assign inputReady2 = w_done2 & ~r_wr2;
  assign ackOutput2  = w_done2 & r_wr2;
  assign data2       = (w_done2 && !r_wr2) ? r_mem[r_addr2] : 'z;

  assign w_unused_bits = ^{address1[WORD_SIZE-1:AW], address2[WORD_SIZE-1:AW], w_enter2};

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench: stimulus pushes expected responses, negedge monitors pop
// and compare data and arrival cycle for a LATENCY=2 and a LATENCY=1 instance.
module tb_memory_responder;

  localparam int L = 2;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        mon_en = 1'b0;

  logic        readM1, readM2, writeM2;
  logic [15:0] address1, address2;
  logic [15:0] data1;
  logic        inputReady1, inputReady2, ackOutput2;
  wire  [15:0] data2;
  logic        tb_drv;
  logic [15:0] tb_wval;

  logic        l1_readM1, l1_readM2, l1_writeM2;
  logic [15:0] l1_address1, l1_address2;
  logic [15:0] l1_data1;
  logic        l1_ready1, l1_ready2, l1_ack2;
  wire  [15:0] l1_data2;
  logic        l1_drv;
  logic [15:0] l1_wval;

  exp_t q1[$], q2r[$], q2a[$], l1q1[$], l1q2r[$], l1q2a[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pullup (data2);
  pullup (l1_data2);
  assign data2    = tb_drv ? tb_wval : 'z;
  assign l1_data2 = l1_drv ? l1_wval : 'z;

  memory_responder #(.LATENCY(L), .MEM_DEPTH(256)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .readM1(readM1), .address1(address1), .data1(data1), .inputReady1(inputReady1),
    .readM2(readM2), .writeM2(writeM2), .address2(address2), .data2(data2),
    .inputReady2(inputReady2), .ackOutput2(ackOutput2)
  );

  memory_responder #(.LATENCY(1), .MEM_DEPTH(256)) u_dut_l1 (
    .clk(clk), .reset_n(reset_n),
    .readM1(l1_readM1), .address1(l1_address1), .data1(l1_data1), .inputReady1(l1_ready1),
    .readM2(l1_readM2), .writeM2(l1_writeM2), .address2(l1_address2), .data2(l1_data2),
    .inputReady2(l1_ready2), .ackOutput2(l1_ack2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Main-instance monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (inputReady1) begin
        chk("ready1_expected", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("ready1_cycle", cyc, e.cyc);
          chk("data1", data1, e.data);
        end
      end
      if (inputReady2) begin
        chk("ready2_expected", q2r.size() != 0, 1);
        if (q2r.size() != 0) begin
          e = q2r.pop_front();
          chk("ready2_cycle", cyc, e.cyc);
          chk("data2_read", data2, e.data);
        end
      end
      if (ackOutput2) begin
        chk("ack2_expected", q2a.size() != 0, 1);
        if (q2a.size() != 0) begin
          e = q2a.pop_front();
          chk("ack2_cycle", cyc, e.cyc);
        end
      end
      if (!inputReady2 && !tb_drv) chk("data2_released", data2, 16'hFFFF);
    end
  end

  // LATENCY=1 instance monitor
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (l1_ready1) begin
        chk("l1_ready1_expected", l1q1.size() != 0, 1);
        if (l1q1.size() != 0) begin
          e = l1q1.pop_front();
          chk("l1_ready1_cycle", cyc, e.cyc);
          chk("l1_data1", l1_data1, e.data);
        end
      end
      if (l1_ready2) begin
        chk("l1_ready2_expected", l1q2r.size() != 0, 1);
        if (l1q2r.size() != 0) begin
          e = l1q2r.pop_front();
          chk("l1_ready2_cycle", cyc, e.cyc);
          chk("l1_data2_read", l1_data2, e.data);
        end
      end
      if (l1_ack2) begin
        chk("l1_ack2_expected", l1q2a.size() != 0, 1);
        if (l1q2a.size() != 0) begin
          e = l1q2a.pop_front();
          chk("l1_ack2_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // All start_* tasks are called just after a rising edge; the next edge samples.
  task automatic start_p1(input logic [15:0] a, input logic [15:0] d);
    readM1 = 1'b1; address1 = a;
    q1.push_back('{cyc + L, d});
  endtask

  task automatic start_p2w(input logic [15:0] a, input logic [15:0] d);
    writeM2 = 1'b1; readM2 = 1'b0; address2 = a; tb_drv = 1'b1; tb_wval = d;
    q2a.push_back('{cyc + L, 16'h0});
  endtask

  task automatic start_p2r(input logic [15:0] a, input logic [15:0] d);
    readM2 = 1'b1; writeM2 = 1'b0; address2 = a;
    q2r.push_back('{cyc + L, d});
  endtask

  task automatic step_release();
    @(posedge clk); #1;
    readM1 = 1'b0; readM2 = 1'b0; writeM2 = 1'b0; tb_drv = 1'b0;
    repeat (L) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    readM1 = 0; readM2 = 0; writeM2 = 0; address1 = '0; address2 = '0;
    tb_drv = 0; tb_wval = '0;
    l1_readM1 = 0; l1_readM2 = 0; l1_writeM2 = 0; l1_address1 = '0; l1_address2 = '0;
    l1_drv = 0; l1_wval = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data1", data1, 16'h0);
    chk("rst_ready1", inputReady1, 0);
    chk("rst_ready2", inputReady2, 0);
    chk("rst_ack2", ackOutput2, 0);
    chk("rst_data2_z", data2, 16'hFFFF);
    chk("rst_l1_data1", l1_data1, 16'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Write then read back on port 2
    start_p2w(16'd5, 16'h1234); step_release();
    start_p2r(16'd5, 16'h1234); step_release();

    // Held port-1 read: one transaction every L+1 cycles
    readM1 = 1'b1; address1 = 16'd5;
    for (int i = 0; i < 3; i++) q1.push_back('{cyc + L + i * (L + 1), 16'h1234});
    repeat (2 * (L + 1) + 1) @(posedge clk);
    #1 readM1 = 1'b0;
    repeat (L) @(posedge clk);
    #1;

    // Aligned collision: port-1 read sees old word, next read sees new
    start_p1(16'd5, 16'h1234);
    start_p2w(16'd5, 16'hBEEF);
    step_release();
    start_p1(16'd5, 16'hBEEF); step_release();

    // Read+write together is a write; upper address bits wrap
    start_p2w(16'h0105, 16'h00AA);
    readM2 = 1'b1;
    step_release();
    start_p1(16'hFF05, 16'h00AA); step_release();
    start_p2r(16'd5, 16'h00AA); step_release();

    // Reset during WAIT abandons the write
    start_p2w(16'd7, 16'h7777); step_release();
    start_p1(16'd7, 16'h7777); step_release();
    writeM2 = 1'b1; address2 = 16'd7; tb_drv = 1'b1; tb_wval = 16'hFFFF;
    @(posedge clk); #1;
    writeM2 = 1'b0; tb_drv = 1'b0; reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_data1", data1, 16'h0);
    chk("midrst_ack2", ackOutput2, 0);
    chk("midrst_ready1", inputReady1, 0);
    chk("midrst_ready2", inputReady2, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (L + 1) @(posedge clk);
    #1;
    start_p1(16'd7, 16'h7777); step_release();
    start_p2r(16'd7, 16'h7777); step_release();

    // LATENCY=1 instance: pulse one cycle after the sampling edge
    l1_writeM2 = 1'b1; l1_address2 = 16'd3; l1_drv = 1'b1; l1_wval = 16'h5A5A;
    l1q2a.push_back('{cyc + 1, 16'h0});
    @(posedge clk); #1;
    l1_writeM2 = 1'b0; l1_drv = 1'b0;
    @(posedge clk); #1;
    l1_readM2 = 1'b1; l1_address2 = 16'd3;
    l1q2r.push_back('{cyc + 1, 16'h5A5A});
    @(posedge clk); #1;
    l1_readM2 = 1'b0;
    @(posedge clk); #1;
    l1_readM1 = 1'b1; l1_address1 = 16'h0203;
    l1q1.push_back('{cyc + 1, 16'h5A5A});
    @(posedge clk); #1;
    l1_readM1 = 1'b0;

    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("q1_drained", q1.size(), 0);
    chk("q2r_drained", q2r.size(), 0);
    chk("q2a_drained", q2a.size(), 0);
    chk("l1q1_drained", l1q1.size(), 0);
    chk("l1q2r_drained", l1q2r.size(), 0);
    chk("l1q2a_drained", l1q2a.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
